multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Parametrised N-channel push-button/switch debouncer; successor to the single-channel transmit-trigger debouncer.
- Per channel: synchroniser chain, saturating up/down integrator with hysteresis, debounced level, one-cycle press/release pulses, optional auto-repeat pulses.
- Sits between board buttons/switches and the UART TX trigger / control logic.
- Single clock domain; all outputs registered.

Parameters:
- NCH, 4, number of independent channels.
- CNT_W, 20, integrator counter width; THRESH must be ≤ 2^CNT_W − 1.
- THRESH, 100000, integrator saturation value; level sets at THRESH, clears at 0.
- SYNC_STAGES, 2, synchroniser flip-flops per channel, minimum 2.
- RPT_W, 27, auto-repeat counter width.
- REPEAT_DLY, 0, cycles from press pulse to first repeat pulse; 0 disables auto-repeat.
- REPEAT_PER, 10000000, cycles between subsequent repeat pulses, ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- btn  in  NCH  raw asynchronous inputs, one bit per channel.
- level  out  NCH  debounced level per channel.
- press  out  NCH  one-cycle pulse on debounced 0→1 transition.
- release  out  NCH  one-cycle pulse on debounced 1→0 transition.
- rpt  out  NCH  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset: rst asserted clears all synchroniser flops, counters, repeat counters, level, press, release and rpt to 0 immediately, regardless of clk.
- Reset mid-debounce discards all progress; a held button must re-qualify from count 0 after rst deasserts.
- Channels are fully independent; no shared state between channels.
- Synchroniser: btn[i] passes through SYNC_STAGES flops; s[i] is the last stage.
- Integrator, each edge, per channel:
  - s=1 and cnt<THRESH: cnt+1.
  - s=0 and cnt>0: cnt−1.
  - Otherwise hold; cnt never wraps.
- Hysteresis state machine, two states per channel (LOW, HIGH):
  - LOW→HIGH on the edge where cnt becomes THRESH; level=1 and press=1 on that same edge.
  - HIGH→LOW on the edge where cnt becomes 0; level=0 and release=1 on that same edge.
  - Chatter between 0 and THRESH never toggles level.
- Latency: btn stable high first sampled at edge 1 → level/press high after edge SYNC_STAGES+THRESH. Release latency is identical.
- press, release and rpt are high for exactly one cycle and mutually exclusive per channel.
- Auto-repeat, active only when REPEAT_DLY>0:
  - Repeat counter clears whenever level=0 or on the press edge.
  - While level=1 it counts every cycle.
  - First rpt fires REPEAT_DLY cycles after the press cycle.
  - Further rpt fire every REPEAT_PER cycles; counter reloads after each rpt with no drift.
  - Release cancels any pending repeat; no rpt on or after the release cycle.
  - RPT_W must hold max(REPEAT_DLY, REPEAT_PER).
- REPEAT_DLY=0: rpt is constant 0.
- Simultaneous events across channels are all reported in the same cycle.

Test Plan:
1. NCH=2, SYNC_STAGES=2, THRESH=4. Drive btn[0]=1 before edge 1 → level[0] and press[0] high after edge 6; press[0] low after edge 7; channel 1 outputs stay 0.
2. THRESH=4, btn[0] pattern 1,1,1,0,1,0,1,1,1,1 (one per cycle) → level rises only when cnt reaches 4; exactly one press, no release, no glitches.
3. From HIGH (cnt=4), drive btn=0 → release pulse and level=0 after 2+4 edges. Then btn=1 for 3 cycles and back to 0 → level stays 0, no press.
4. REPEAT_DLY=10, REPEAT_PER=5, hold btn → rpt at press+10, +15, +20. Release at press+17 → no rpt at +20 or later.
5. Assert rst asynchronously mid-count (cnt=3) and mid-HIGH → all outputs 0 immediately, with no release pulse. After deassert with btn held, press after a further 6 edges.
6. Both channels pressed on the same cycle → press[1:0]=2'b11 in one cycle. Then with THRESH = 2^CNT_W−1 (CNT_W=3, THRESH=7), hold 20 cycles → cnt saturates at 7, no wrap, level stays 1.

Source files
------------

// File: rtl/multi_debouncer.sv
// N-channel button/switch debouncer: per-channel synchroniser, saturating
// integrator with hysteresis, press/release pulses and optional auto-repeat.

module multi_debouncer_ch #(
  parameter int CNT_W       = 20,
  parameter int THRESH      = 100000,
  parameter int SYNC_STAGES = 2,
  parameter int RPT_W       = 27,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_PER  = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  typedef enum logic {LOW, HIGH} state_e;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= LOW;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Saturating integrator: counts toward the synchronised input, never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (s && (cnt_q < THR))
      cnt_d = cnt_q + CNT_W'(1);
    else if (!s && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Level only moves at the rails, so chatter in between is ignored.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      LOW: if (cnt_d == THR) begin
        state_d = HIGH;
        press_d = 1'b1;
      end
      HIGH: if (cnt_d == '0) begin
        state_d   = LOW;
        release_d = 1'b1;
      end
      default: state_d = LOW;
    endcase
  end

  assign level_o   = (state_q == HIGH);
  assign press_o   = press_q;
  assign release_o = release_q;

  if (REPEAT_DLY > 0) begin : g_rpt
    localparam logic [RPT_W-1:0] DLY_M1 = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_M1 = RPT_W'(REPEAT_PER - 1);

    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic             first_q, first_d;
    logic             rpt_q, rpt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rcnt_q  <= '0;
        first_q <= 1'b1;
        rpt_q   <= 1'b0;
      end else begin
        rcnt_q  <= rcnt_d;
        first_q <= first_d;
        rpt_q   <= rpt_d;
      end
    end

    // Counter restarts at every rpt, so the period never accumulates drift.
    always_comb begin
      rcnt_d  = rcnt_q + RPT_W'(1);
      first_d = first_q;
      rpt_d   = 1'b0;
      if ((state_d != HIGH) || press_d) begin
        rcnt_d  = '0;
        first_d = 1'b1;
      end else if (rcnt_q == (first_q ? DLY_M1 : PER_M1)) begin
        rpt_d   = 1'b1;
        rcnt_d  = '0;
        first_d = 1'b0;
      end
    end

    assign rpt_o = rpt_q;
  end else begin : g_norpt
    assign rpt_o = 1'b0;
  end

endmodule

module multi_debouncer #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 20,
  parameter int THRESH      = 100000,
  parameter int SYNC_STAGES = 2,
  parameter int RPT_W       = 27,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_PER  = 10000000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] btn_i,
  output logic [NCH-1:0] level_o,
  output logic [NCH-1:0] press_o,
  output logic [NCH-1:0] release_o,
  output logic [NCH-1:0] rpt_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    multi_debouncer_ch #(
      .CNT_W      (CNT_W),
      .THRESH     (THRESH),
      .SYNC_STAGES(SYNC_STAGES),
      .RPT_W      (RPT_W),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn_i    (btn_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .rpt_o    (rpt_o[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: two instances (THRESH=4 with auto-repeat,
// THRESH=7 saturating 3-bit counter without repeat) checked every cycle.

module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_a, btn_b;
  logic [1:0] lvl_a, prs_a, rel_a, rpt_a;
  logic [1:0] lvl_b, prs_b, rel_b, rpt_b;

  always #5 clk = ~clk;

  multi_debouncer #(
    .NCH(2), .CNT_W(3), .THRESH(4), .SYNC_STAGES(2),
    .RPT_W(8), .REPEAT_DLY(10), .REPEAT_PER(5)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_a),
    .level_o(lvl_a), .press_o(prs_a), .release_o(rel_a), .rpt_o(rpt_a)
  );

  multi_debouncer #(
    .NCH(2), .CNT_W(3), .THRESH(7), .SYNC_STAGES(2),
    .RPT_W(8), .REPEAT_DLY(0), .REPEAT_PER(1)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_b),
    .level_o(lvl_b), .press_o(prs_b), .release_o(rel_b), .rpt_o(rpt_b)
  );

  typedef struct { logic [1:0] btn; logic [7:0] exp; } vec_t;
  typedef struct { string name; logic [15:0] exp; } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected output word per instance: {level, press, release, rpt}.
  function automatic logic [7:0] ex(logic [1:0] l, logic [1:0] p, logic [1:0] r, logic [1:0] t);
    return {l, p, r, t};
  endfunction

  function automatic void add(int n, logic [1:0] b, logic [1:0] l, logic [1:0] p,
                              logic [1:0] r, logic [1:0] t);
    for (int i = 0; i < n; i++) tbl.push_back('{btn: b, exp: ex(l, p, r, t)});
  endfunction

  task automatic check();
    sb_t         e;
    logic [15:0] act;
    act = {lvl_a, prs_a, rel_a, rpt_a, lvl_b, prs_b, rel_b, rpt_b};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %b, no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (A lvl,prs,rel,rpt | B lvl,prs,rel,rpt)",
                 e.name, act, e.exp);
      end
    end
  endtask

  // One clock edge: drive at negedge, queue expectation, compare after posedge.
  task automatic step(string nm, logic [1:0] ba, logic [1:0] bb, logic [7:0] ea, logic [7:0] eb);
    @(negedge clk);
    btn_a = ba;
    btn_b = bb;
    sb_q.push_back('{name: nm, exp: {ea, eb}});
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic async_rst_check(string nm);
    #2 rst = 1'b1;
    sb_q.push_back('{name: nm, exp: 16'h0000});
    #1 check();
  endtask

  // Hold ch0, expect press; drop so release lands at press+rel_at.
  task automatic run_rpt(int rel_at);
    logic [1:0] b, l, r, t;
    for (int k = 1; k <= 5; k++) step("rpt_qual", 2'b01, 2'b00, 8'h00, 8'h00);
    step("rpt_press", 2'b01, 2'b00, ex(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
    for (int k = 1; k <= rel_at + 2; k++) begin
      b = (k <= rel_at - 6) ? 2'b01 : 2'b00;
      l = (k < rel_at) ? 2'b01 : 2'b00;
      r = (k == rel_at) ? 2'b01 : 2'b00;
      t = (k < rel_at && k >= 10 && (k - 10) % 5 == 0) ? 2'b01 : 2'b00;
      step($sformatf("rpt%0d_k%0d", rel_at, k), b, 2'b00, ex(l, 2'b00, r, t), 8'h00);
    end
  endtask

  initial begin
    // btn, level, press, release, rpt (channel bits 1:0)
    add(5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);   // qualify ch0
    add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);   // press after edge 6
    add(2, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);   // release qualifying
    add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);   // short blip: no press
    add(5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);   // chatter 1,1,1,0,1,0,1,1,1,1
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);   // cnt reaches 4
    add(2, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);   // both channels together
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    add(2, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    rst   = 1'b1;
    btn_a = 2'b00;
    btn_b = 2'b00;
    #12;
    sb_q.push_back('{name: "reset_state", exp: 16'h0000});
    check();
    rst = 1'b0;

    foreach (tbl[i]) step($sformatf("tbl%0d", i + 1), tbl[i].btn, 2'b00, tbl[i].exp, 8'h00);

    // Auto-repeat: release at press+17 cancels +20; second run sees +20.
    run_rpt(17);
    run_rpt(23);

    // Reset mid-count: progress discarded, full re-qualification.
    for (int k = 1; k <= 5; k++) step("rc_qual", 2'b01, 2'b00, 8'h00, 8'h00);
    async_rst_check("rst_midcount");
    step("rst_hold1", 2'b01, 2'b00, 8'h00, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) step($sformatf("rc_requal%0d", k), 2'b01, 2'b00, 8'h00, 8'h00);
    step("rc_press", 2'b01, 2'b00, ex(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
    step("rc_high", 2'b01, 2'b00, ex(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
    // Reset while HIGH: immediate clear, no release pulse.
    async_rst_check("rst_midhigh");
    step("rst_hold2", 2'b01, 2'b00, 8'h00, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) step($sformatf("rh_requal%0d", k), 2'b01, 2'b00, 8'h00, 8'h00);
    step("rh_press", 2'b01, 2'b00, ex(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
    for (int k = 1; k <= 5; k++) step("rh_drop", 2'b00, 2'b00, ex(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
    step("rh_release", 2'b00, 2'b00, ex(2'b00, 2'b00, 2'b01, 2'b00), 8'h00);
    step("rh_idle", 2'b00, 2'b00, 8'h00, 8'h00);

    // Saturation at 2^CNT_W-1: hold long, then release takes full THRESH again.
    for (int k = 1; k <= 8; k++) step($sformatf("sat_qual%0d", k), 2'b00, 2'b11, 8'h00, 8'h00);
    step("sat_press", 2'b00, 2'b11, 8'h00, ex(2'b11, 2'b11, 2'b00, 2'b00));
    for (int k = 1; k <= 20; k++)
      step($sformatf("sat_hold%0d", k), 2'b00, 2'b11, 8'h00, ex(2'b11, 2'b00, 2'b00, 2'b00));
    for (int k = 1; k <= 8; k++)
      step($sformatf("sat_drop%0d", k), 2'b00, 2'b00, 8'h00, ex(2'b11, 2'b00, 2'b00, 2'b00));
    step("sat_release", 2'b00, 2'b00, 8'h00, ex(2'b00, 2'b00, 2'b11, 2'b00));
    step("sat_idle", 2'b00, 2'b00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
